// File: rtl/reg_file_scoreboard_if.sv
// Register-file/scoreboard bus: two read ports, one writeback port and one issue port.
// The slave modport is the register file; the master modport drives it.
interface reg_file_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] readAddress0;
  logic [ADDR_W-1:0] readAddress1;
  logic [DATA_W-1:0] readData0;
  logic [DATA_W-1:0] readData1;
  logic              hazard0;
  logic              hazard1;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] writeData;
  logic              issueValid;
  logic [ADDR_W-1:0] issueAddress;
  logic              issueAccept;
  logic [ADDR_W:0]   pendingCount;
  logic              wbError;

  modport slave (
    input  readAddress0, readAddress1, writeEnable, writeAddress, writeData,
           issueValid, issueAddress,
    output readData0, readData1, hazard0, hazard1, issueAccept, pendingCount, wbError
  );

  modport master (
    output readAddress0, readAddress1, writeEnable, writeAddress, writeData,
           issueValid, issueAddress,
    input  readData0, readData1, hazard0, hazard1, issueAccept, pendingCount, wbError
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register busy bits; reads, hazards and issueAccept are combinational.
// A WAW issue is refused unless the same register retires this cycle; pendingCount/wbError update on the edge.
module reg_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  reg_file_scoreboard_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_pending;
  logic              r_wb_error;

  logic              w_zero_rd0;
  logic              w_zero_rd1;
  logic              w_zero_wr;
  logic              w_zero_iss;
  logic              w_byp0;
  logic              w_byp1;
  logic              w_byp_iss;
  logic              w_accept;
  logic              w_wr;
  logic              w_set;
  logic              w_inc;
  logic              w_dec;
  logic              w_wb_err;
  logic [DEPTH-1:0]  w_busy_nxt;

  assign w_zero_rd0 = (ZERO_REG != 0) && (bus.readAddress0 == '0);
  assign w_zero_rd1 = (ZERO_REG != 0) && (bus.readAddress1 == '0);
  assign w_zero_wr  = (ZERO_REG != 0) && (bus.writeAddress == '0);
  assign w_zero_iss = (ZERO_REG != 0) && (bus.issueAddress == '0);

  assign w_byp0    = bus.writeEnable && (bus.writeAddress == bus.readAddress0);
  assign w_byp1    = bus.writeEnable && (bus.writeAddress == bus.readAddress1);
  assign w_byp_iss = bus.writeEnable && (bus.writeAddress == bus.issueAddress);

  assign bus.readData0 = w_zero_rd0 ? '0 : (w_byp0 ? bus.writeData : r_data[bus.readAddress0]);
  assign bus.readData1 = w_zero_rd1 ? '0 : (w_byp1 ? bus.writeData : r_data[bus.readAddress1]);
  assign bus.hazard0   = !w_zero_rd0 && r_busy[bus.readAddress0] && !w_byp0;
  assign bus.hazard1   = !w_zero_rd1 && r_busy[bus.readAddress1] && !w_byp1;

  assign w_accept        = bus.issueValid && (!r_busy[bus.issueAddress] || w_byp_iss);
  assign bus.issueAccept = w_accept;

  assign w_wr     = bus.writeEnable && !w_zero_wr;
  assign w_set    = w_accept && !w_zero_iss;
  assign w_wb_err = w_wr && !r_busy[bus.writeAddress];

  // Count only real bit transitions: a retire+reissue of one register nets to zero.
  assign w_inc = w_set && !r_busy[bus.issueAddress];
  assign w_dec = w_wr && r_busy[bus.writeAddress] &&
                 !(w_set && (bus.issueAddress == bus.writeAddress));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr)  w_busy_nxt[bus.writeAddress] = 1'b0;
    if (w_set) w_busy_nxt[bus.issueAddress] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_busy     <= '0;
      r_pending  <= '0;
      r_wb_error <= 1'b0;
    end else begin
      if (w_wr) r_data[bus.writeAddress] <= bus.writeData;
      r_busy     <= w_busy_nxt;
      r_pending  <= r_pending + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
      r_wb_error <= w_wb_err;
    end
  end

  assign bus.pendingCount = r_pending;
  assign bus.wbError      = r_wb_error;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Randomized bench for reg_file_scoreboard against an array-based reference model.
// Directed scenarios cover the reset, WAW, bypass, zero-register and error-flag cases.
module tb_reg_file_scoreboard;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic resetN;

  reg_file_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] mdl_data [DEPTH];
  bit            mdl_busy [DEPTH];
  bit            mdl_err;
  bit            mdl_init = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mdl_pending();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (mdl_busy[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] mdl_read(input int a, input bit we, input int wa,
                                             input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return mdl_data[a];
  endfunction

  function automatic bit mdl_hazard(input int a, input bit we, input int wa);
    if (a == 0) return 1'b0;
    return mdl_busy[a] && !(we && wa == a);
  endfunction

  // One clock: apply inputs, check combinational and registered outputs, advance the model.
  task automatic cyc(input bit rst_n, input int ra0, input int ra1, input bit we, input int wa,
                     input logic [DW-1:0] wd, input bit iv, input int ia);
    bit acc;
    resetN           = rst_n;
    bus.readAddress0 = AW'(ra0);
    bus.readAddress1 = AW'(ra1);
    bus.writeEnable  = we;
    bus.writeAddress = AW'(wa);
    bus.writeData    = wd;
    bus.issueValid   = iv;
    bus.issueAddress = AW'(ia);
    #2;
    acc = iv && (!mdl_busy[ia] || (we && wa == ia));
    if (mdl_init) begin
      check("readData0", 64'(bus.readData0), 64'(mdl_read(ra0, we, wa, wd)));
      check("readData1", 64'(bus.readData1), 64'(mdl_read(ra1, we, wa, wd)));
      check("hazard0", 64'(bus.hazard0), 64'(mdl_hazard(ra0, we, wa)));
      check("hazard1", 64'(bus.hazard1), 64'(mdl_hazard(ra1, we, wa)));
      check("issueAccept", 64'(bus.issueAccept), 64'(acc));
      check("pendingCount", 64'(bus.pendingCount), 64'(mdl_pending()));
      check("wbError", 64'(bus.wbError), 64'(mdl_err));
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mdl_data[i] = '0;
        mdl_busy[i] = 1'b0;
      end
      mdl_err  = 1'b0;
      mdl_init = 1'b1;
    end else begin
      mdl_err = 1'b0;
      if (we && wa != 0) begin
        mdl_err      = !mdl_busy[wa];
        mdl_data[wa] = wd;
        mdl_busy[wa] = 1'b0;
      end
      if (acc && ia != 0) mdl_busy[ia] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int ra0, input int ra1);
    cyc(1, ra0, ra1, 0, 0, '0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mdl_data[i] = '0;
      mdl_busy[i] = 1'b0;
    end
    mdl_err = 1'b0;
    #1;
    cyc(0, 0, 0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, 1, 4, 32'hAAAA5555, 1, 6);

    // Post-reset reads of 3 and 31; issueAccept follows issueValid
    cyc(1, 3, 31, 0, 0, '0, 1, 0);

    // Reserve 5, refuse WAW, retire with bypass
    cyc(1, 0, 0, 0, 0, '0, 1, 5);
    cyc(1, 5, 0, 0, 0, '0, 1, 5);
    cyc(1, 5, 5, 1, 5, 32'hDEADBEEF, 0, 0);
    idle(5, 0);

    // Retire and re-reserve 7 in one cycle
    cyc(1, 0, 0, 0, 0, '0, 1, 7);
    cyc(1, 7, 0, 1, 7, 32'h12345678, 1, 7);
    idle(7, 7);
    cyc(1, 7, 0, 1, 7, 32'h0BADF00D, 0, 0);

    // Register 0 stays zero and never busy
    cyc(1, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
    idle(0, 0);

    // Writeback to idle register 9 flags an error for one cycle
    cyc(1, 0, 0, 1, 9, 32'hCAFE0009, 0, 0);
    idle(9, 0);
    idle(9, 9);

    // Reset drops reservations; later retire of 2 is an error
    cyc(1, 0, 0, 0, 0, '0, 1, 1);
    cyc(1, 0, 0, 0, 0, '0, 1, 2);
    cyc(1, 1, 2, 0, 0, '0, 1, 3);
    cyc(0, 1, 2, 1, 1, 32'h11111111, 1, 4);
    idle(1, 3);
    cyc(1, 2, 0, 1, 2, 32'h22222222, 0, 0);
    idle(2, 0);

    // Random traffic with clustered addresses to force collisions
    for (int n = 0; n < 800; n++) begin
      int ra0, ra1, wa, ia;
      bit rst_n;
      ra0   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
      ra1   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
      wa    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
      ia    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(rst_n, ra0, ra1, ($urandom_range(0, 2) == 0), wa, $urandom,
          ($urandom_range(0, 1) != 0), ia);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
